// File: rtl/prog_clk_div.sv
// Programmable multi-channel clock divider with shadowed divisor writes.
// Optional free-running counter output enabled by defining PROG_CLK_DIV_FREERUN_EN.
module prog_clk_div #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic             wr_err,
    output logic [N_CH-1:0]  pend,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_out
`ifdef PROG_CLK_DIV_FREERUN_EN
    ,
    output logic [CNT_W-1:0] freerun
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] div_q    [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] shadow_q [N_CH];
    logic [N_CH-1:0]  sel;
    logic             wr_in_range;
    logic             accept;

    // One-hot decode of wr_ch; all-zero when the index is out of range.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sel[i] = (wr_ch == 4'(i));
        end
    end

    assign wr_in_range = |sel;
    assign wr_ready    = ~|(sel & pend);
    assign accept      = wr_valid & wr_ready;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                div_q[i]    <= '0;
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            pend    <= '0;
            tick    <= '0;
            clk_out <= '0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= accept & ~wr_in_range;
            for (int unsigned i = 0; i < N_CH; i++) begin
                tick[i] <= 1'b0;
                if (div_q[i] == '0) begin
                    if (accept && sel[i]) begin
                        div_q[i] <= wr_div;
                        cnt_q[i] <= '0;
                    end
                end else begin
                    if (cnt_q[i] == div_q[i] - ONE) begin
                        cnt_q[i] <= '0;
                        if (pend[i] && (shadow_q[i] == '0)) begin
                            div_q[i]   <= '0;
                            clk_out[i] <= 1'b0;
                            pend[i]    <= 1'b0;
                        end else begin
                            tick[i]    <= 1'b1;
                            clk_out[i] <= ~clk_out[i];
                            if (pend[i]) begin
                                div_q[i] <= shadow_q[i];
                                pend[i]  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + ONE;
                    end
                    // pend is clear whenever a write is accepted, so this never races the swap above
                    if (accept && sel[i]) begin
                        shadow_q[i] <= wr_div;
                        pend[i]     <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PROG_CLK_DIV_FREERUN_EN
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            freerun <= '0;
        end else begin
            freerun <= freerun + ONE;
        end
    end
`endif

endmodule
